// File: rtl/tone_pkg.sv
// Shared constants and types for the tone detector: note table, tolerance shift, FSM states.
package tone_pkg;

    localparam int unsigned NOTE_W    = 3;
    localparam int unsigned NUM_NOTES = 8;
    localparam int unsigned TOL_SHIFT = 6;

    // Half-periods in 16 MHz cycles, C4 .. C5
    localparam logic [15:0] NOTE_HALF [NUM_NOTES] = '{
        16'd30578, 16'd27242, 16'd24270, 16'd22908,
        16'd20408, 16'd18182, 16'd16198, 16'd15289
    };

    typedef enum logic {IDLE, MEASURE} state_e;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer followed by a registered any-edge detector.
module sync_edge (
    input  logic CLK,
    input  logic RST_N,
    input  logic ASYNC_IN,
    output logic EDGE_STB
);

    logic sync1_q, sync2_q, prev_q, stb_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            stb_q   <= 1'b0;
        end else begin
            sync1_q <= ASYNC_IN;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            stb_q   <= sync2_q ^ prev_q;
        end
    end

    assign EDGE_STB = stb_q;

endmodule

// File: rtl/tone_detector.sv
// Measures the half-period of an asynchronous square wave and matches it against the
// C4..C5 note table, reporting note, hit, lock and silence status.
module tone_detector
    import tone_pkg::*;
#(
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned MIN_HALF   = 1000,
    parameter int unsigned TIMEOUT    = 65535,
    parameter int unsigned LOCK_COUNT = 4
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              TONE_IN,
    output logic [CNT_W-1:0]  HALF_PERIOD,
    output logic              HALF_VALID,
    output logic [NOTE_W-1:0] NOTE,
    output logic              NOTE_HIT,
    output logic              LOCKED,
    output logic              SILENT
);

    localparam int unsigned MW       = CNT_W + 1;
    localparam int unsigned STREAK_W = $clog2(LOCK_COUNT + 1);

    localparam logic [CNT_W-1:0]    TIMEOUT_C  = CNT_W'(TIMEOUT);
    localparam logic [MW-1:0]       MIN_HALF_C = MW'(MIN_HALF);
    localparam logic [STREAK_W-1:0] LOCK_C     = STREAK_W'(LOCK_COUNT);

    logic edge_stb;

    sync_edge u_sync_edge (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .ASYNC_IN (TONE_IN),
        .EDGE_STB (edge_stb)
    );

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    half_q, half_d;
    logic                valid_q, valid_d;
    logic [NOTE_W-1:0]   note_q, note_d;
    logic                hit_q, hit_d;
    logic [STREAK_W-1:0] streak_q, streak_d;

    logic [MW-1:0]     meas;
    logic [MW-1:0]     tbl, tol, diff;
    logic              match_any;
    logic [NOTE_W-1:0] match_idx;
    logic              at_limit;

    // Cycles since the previous accepted strobe, including this one
    assign meas     = {1'b0, cnt_q} + MW'(1);
    assign at_limit = (cnt_q >= TIMEOUT_C - CNT_W'(1));

    // Descending scan so the lowest matching index wins
    always_comb begin
        match_any = 1'b0;
        match_idx = '0;
        tbl       = '0;
        tol       = '0;
        diff      = '0;
        for (int i = int'(NUM_NOTES) - 1; i >= 0; i--) begin
            tbl  = MW'(NOTE_HALF[i]);
            tol  = tbl >> TOL_SHIFT;
            diff = (meas >= tbl) ? (meas - tbl) : (tbl - meas);
            if (diff <= tol) begin
                match_any = 1'b1;
                match_idx = NOTE_W'(i);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        half_d   = half_q;
        valid_d  = 1'b0;
        note_d   = note_q;
        hit_d    = hit_q;
        streak_d = streak_q;

        unique case (state_q)
            IDLE: begin
                if (edge_stb) begin
                    state_d = MEASURE;
                    cnt_d   = '0;
                end
            end
            MEASURE: begin
                if (edge_stb && (meas >= MIN_HALF_C)) begin
                    // Accepted edge beats a coincident timeout
                    half_d  = meas[CNT_W-1:0];
                    valid_d = 1'b1;
                    cnt_d   = '0;
                    if (match_any) begin
                        note_d = match_idx;
                        hit_d  = 1'b1;
                        if ((streak_q != '0) && (note_q == match_idx)) begin
                            streak_d = (streak_q == LOCK_C) ? streak_q
                                                            : streak_q + STREAK_W'(1);
                        end else begin
                            streak_d = STREAK_W'(1);
                        end
                    end else begin
                        hit_d    = 1'b0;
                        streak_d = '0;
                    end
                end else begin
                    if (edge_stb) begin
                        streak_d = '0;
                    end
                    if (at_limit) begin
                        state_d  = IDLE;
                        cnt_d    = TIMEOUT_C;
                        streak_d = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            half_q   <= '0;
            valid_q  <= 1'b0;
            note_q   <= '0;
            hit_q    <= 1'b0;
            streak_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            half_q   <= half_d;
            valid_q  <= valid_d;
            note_q   <= note_d;
            hit_q    <= hit_d;
            streak_q <= streak_d;
        end
    end

    assign HALF_PERIOD = half_q;
    assign HALF_VALID  = valid_q;
    assign NOTE        = note_q;
    assign NOTE_HIT    = hit_q;
    assign LOCKED      = (streak_q == LOCK_C);
    assign SILENT      = (state_q == IDLE);

endmodule

// File: tb/tb_tone_detector.sv
// Scoreboard bench for tone_detector: toggle-time reference model feeds an expected queue,
// a negedge monitor pops and compares on every HALF_VALID.
module tb_tone_detector;

    localparam int CNT_W      = 16;
    localparam int MIN_HALF   = 100;
    localparam int TIMEOUT    = 15600;
    localparam int LOCK_COUNT = 2;

    logic             CLK = 1'b0;
    logic             RST_N = 1'b0;
    logic             TONE_IN = 1'b0;
    logic [CNT_W-1:0] HALF_PERIOD;
    logic             HALF_VALID;
    logic [2:0]       NOTE;
    logic             NOTE_HIT;
    logic             LOCKED;
    logic             SILENT;

    tone_detector #(
        .CNT_W      (CNT_W),
        .MIN_HALF   (MIN_HALF),
        .TIMEOUT    (TIMEOUT),
        .LOCK_COUNT (LOCK_COUNT)
    ) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .TONE_IN     (TONE_IN),
        .HALF_PERIOD (HALF_PERIOD),
        .HALF_VALID  (HALF_VALID),
        .NOTE        (NOTE),
        .NOTE_HIT    (NOTE_HIT),
        .LOCKED      (LOCKED),
        .SILENT      (SILENT)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int d;
        int note;
        int hit;
        int locked;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    int note_tab[8] = '{30578, 27242, 24270, 22908, 20408, 18182, 16198, 15289};

    // Reference model state, expressed in pin-toggle times
    bit m_active;
    int m_last;
    int m_note;
    int m_hit;
    int m_streak;
    int m_last_half;

    function automatic void check(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void model_reset();
        m_active    = 1'b0;
        m_last      = 0;
        m_note      = 0;
        m_hit       = 0;
        m_streak    = 0;
        m_last_half = 0;
        q.delete();
    endfunction

    function automatic void model_edge(int t);
        int d;
        int idx;
        if (!m_active || (t - m_last) > TIMEOUT) begin
            m_active = 1'b1;
            m_last   = t;
            m_streak = 0;
            return;
        end
        d = t - m_last;
        if (d < MIN_HALF) begin
            m_streak = 0;
            return;
        end
        m_last = t;
        idx = -1;
        for (int i = 0; i < 8; i++) begin
            if (idx < 0 && d >= note_tab[i] - note_tab[i] / 64
                        && d <= note_tab[i] + note_tab[i] / 64) idx = i;
        end
        if (idx >= 0) begin
            if (m_streak > 0 && idx == m_note)
                m_streak = (m_streak + 1 > LOCK_COUNT) ? LOCK_COUNT : m_streak + 1;
            else
                m_streak = 1;
            m_note = idx;
            m_hit  = 1;
        end else begin
            m_hit    = 0;
            m_streak = 0;
        end
        m_last_half = d;
        q.push_back('{d, m_note, m_hit, (m_streak == LOCK_COUNT) ? 1 : 0});
    endfunction

    task automatic toggle_after(int n);
        repeat (n) @(posedge CLK);
        #1;
        TONE_IN = ~TONE_IN;
        model_edge(cyc);
    endtask

    task automatic check_reset_values(string tag);
        check({tag, "_half_period"}, int'(HALF_PERIOD), 0);
        check({tag, "_half_valid"}, int'(HALF_VALID), 0);
        check({tag, "_note"}, int'(NOTE), 0);
        check({tag, "_note_hit"}, int'(NOTE_HIT), 0);
        check({tag, "_locked"}, int'(LOCKED), 0);
        check({tag, "_silent"}, int'(SILENT), 1);
    endtask

    // Monitor
    always @(negedge CLK) begin
        exp_t e;
        if (RST_N && HALF_VALID) begin
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_half_valid: got HALF_PERIOD=%0d, expected no strobe",
                         HALF_PERIOD);
            end else begin
                e = q.pop_front();
                check("half_period", int'(HALF_PERIOD), e.d);
                check("note", int'(NOTE), e.note);
                check("note_hit", int'(NOTE_HIT), e.hit);
                check("locked", int'(LOCKED), e.locked);
            end
        end
    end

    int bnd[3] = '{99, 100, 101};

    initial begin
        model_reset();

        // Reset held with the pin toggling
        RST_N = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge CLK);
            #1 TONE_IN = ~TONE_IN;
            @(negedge CLK);
            check_reset_values("in_reset");
        end
        TONE_IN = 1'b0;
        @(posedge CLK);
        #1 RST_N = 1'b1;
        repeat (5) @(negedge CLK);
        check("post_reset_silent", int'(SILENT), 1);
        @(posedge CLK);
        #1;

        // Random short intervals: glitches, MIN_HALF boundary, out-of-table misses
        toggle_after(50);
        for (int i = 0; i < 24; i++) begin
            if (i % 8 == 3) toggle_after(bnd[(i / 8) % 3]);
            else            toggle_after($urandom_range(20, 400));
        end

        // Directed note sequence: miss, hit, glitch pair, hit, boundary hit (lock)
        toggle_after(15289 + 239);
        toggle_after(15289);
        toggle_after(30);
        toggle_after(10);
        toggle_after(15289 - 40);
        toggle_after(15289 + 238);

        // Silence: counter reaches TIMEOUT one cycle after the strobe-to-output latency
        repeat (3 + TIMEOUT) @(posedge CLK);
        @(negedge CLK);
        check("pre_timeout_silent", int'(SILENT), 0);
        check("pre_timeout_locked", int'(LOCKED), 1);
        @(negedge CLK);
        check("timeout_silent", int'(SILENT), 1);
        check("timeout_locked", int'(LOCKED), 0);
        check("timeout_half_hold", int'(HALF_PERIOD), m_last_half);
        check("timeout_note_hold", int'(NOTE), 7);
        check("timeout_hit_hold", int'(NOTE_HIT), 1);

        // Mid-measurement reset
        toggle_after(20);
        toggle_after(300);
        repeat (150) @(posedge CLK);
        #1 RST_N = 1'b0;
        TONE_IN = 1'b0;
        #1;
        check_reset_values("async_reset");
        model_reset();
        repeat (3) @(posedge CLK);
        #1 RST_N = 1'b1;
        toggle_after(40);
        toggle_after(250);
        repeat (12) @(negedge CLK);
        check("scoreboard_drained", q.size(), 0);
        check("final_half_period", int'(HALF_PERIOD), 250);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tone_detector.md
# tone_detector

Receive-side counterpart to the square-wave tone generators that drive SPEAKER. Samples an asynchronous square-wave input (tone pin from another board, or a comparator on a microphone) and measures the half-period in CLK cycles. Matches the measurement against a fixed C4–C5 note table and reports note, lock and silence status. Sits between a GPIO pin and LEDs or downstream music logic on the 16 MHz TinyFPGA BX.

## Interface
- `CNT_W`, default 16: width of the half-period counter and measurement.
- `MIN_HALF`, default 1000: minimum accepted half-period in cycles. Shorter edges are glitches.
- `TIMEOUT`, default 65535: cycles without an accepted edge before declaring silence. Must be < 2^CNT_W.
- `LOCK_COUNT`, default 4: consecutive hits on the same note required for LOCKED.
- `CLK` input, 1 bit: 16 MHz clock. This is the only clock.
- `RST_N` input, 1 bit: asynchronous, active-low reset.
- `TONE_IN` input, 1 bit: asynchronous square-wave input.
- `HALF_PERIOD` output, CNT_W bits: last accepted half-period in cycles.
- `HALF_VALID` output, 1 bit: one-cycle strobe when HALF_PERIOD updates.
- `NOTE` output, 3 bits: table index of the last measurement (0=C4 … 7=C5).
- `NOTE_HIT` output, 1 bit: last measurement lies within tolerance of NOTE.
- `LOCKED` output, 1 bit: LOCK_COUNT consecutive hits on the same NOTE.
- `SILENT` output, 1 bit: no accepted edge for TIMEOUT cycles, or since reset.

## Operation
- **Input path:** TONE_IN passes through a 2-flop synchronizer, then an edge detector. Both rising and falling edges produce an edge strobe.
- **State machine, two states:**
  - IDLE (reset state): SILENT=1. The first edge strobe clears the counter, moves to MEASURE and deasserts SILENT. No measurement is produced on this edge.
  - MEASURE: the counter increments every cycle. On an edge strobe, D = cycles since the previous accepted strobe (counter value + 1).
    - D ≥ MIN_HALF: edge accepted. HALF_PERIOD←D, HALF_VALID pulses, note match runs, counter clears.
    - D < MIN_HALF: edge ignored as a glitch. Counter keeps running, lock streak clears, no HALF_VALID.
  - MEASURE → IDLE: when the counter reaches TIMEOUT, go to IDLE. SILENT←1, LOCKED←0, streak clears. HALF_PERIOD, NOTE and NOTE_HIT hold their values.
- **Note match:** for each table entry T, the measurement is a hit if |D−T| ≤ T>>6 (about ±1.6 %).
  - NOTE = lowest matching index. The table spacing guarantees at most one match.
  - On no match: NOTE_HIT=0, NOTE holds, streak clears.
- **Lock streak:**
  - Hit on the same NOTE as the previous hit: streak+1, saturating at LOCK_COUNT.
  - Hit on a different NOTE: streak←1.
  - LOCKED = (streak == LOCK_COUNT).
- **Arithmetic:**
  - The counter saturates at TIMEOUT and never wraps.
  - The tolerance compare is unsigned, at CNT_W+1 bits.
- **Reset values:** HALF_PERIOD=0, HALF_VALID=0, NOTE=0, NOTE_HIT=0, LOCKED=0, SILENT=1, state=IDLE, streak=0. Asserting RST_N mid-measurement discards the partial count immediately.

## Timing
- Pin change to edge strobe: 3 CLK (2 sync + 1 detect).
- Edge strobe to outputs: HALF_VALID, HALF_PERIOD, NOTE and NOTE_HIT register on the cycle after the strobe. LOCKED updates in that same cycle.
- The note compare is combinational in that one cycle, so latency is fixed at 1 cycle after the strobe.
- A source toggling every N+1 cycles measures D=N+1 exactly, with no jitter.
- SILENT asserts on the cycle the counter reaches TIMEOUT.
- Simultaneous edge strobe and timeout: the edge wins. It is evaluated as a normal edge and no transition to IDLE occurs.

## Structure
- Package `tone_pkg` holds:
  - `NOTE_W`=3.
  - `NOTE_HALF`, an array of 8 CNT_W constants for 16 MHz: 30578, 27242, 24270, 22908, 20408, 18182, 16198, 15289.
  - `TOL_SHIFT`=6.
  - The state enum {IDLE, MEASURE}.
- One sub-module, `sync_edge`: 2-flop synchronizer plus edge detector, with an async active-low reset to 0.

## Test plan
- **Reset:** hold RST_N=0 with TONE_IN toggling → all outputs at their reset values, SILENT=1, no HALF_VALID.
- **C4 tone:** half-period 30578 → no output on the first edge. Second edge gives HALF_PERIOD=30578, NOTE=0, NOTE_HIT=1. LOCKED=1 after the 5th edge.
- **Tolerance:** half-period 18182+284 → NOTE=5, NOTE_HIT=1. Half-period 18182+300 → NOTE_HIT=0, LOCKED drops.
- **Glitch:** steady G4 (20408) with a 10-cycle pulse injected mid half-period → no HALF_VALID for the glitch, streak clears. The next accepted measurement is the original edge-to-edge count, not a fresh 20408 from the glitch.
- **Silence:** stop toggling after lock → exactly TIMEOUT cycles after the last accepted strobe, SILENT=1 and LOCKED=0, with HALF_PERIOD held.
- **Mid-measure reset:** pulse RST_N low halfway through a half-period → outputs reset asynchronously. After release, the first edge produces no measurement and the second edge does.
